// File: rtl/ysyx_22040759_mem_arbiter_if.sv
// Request/response and RAM-port bundle shared by the IF/LS front ends, the arbiter and the RAM helper.
// master = requesters plus RAM side, slave = the arbiter.
interface ysyx_22040759_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_resp_valid;
   logic              if_resp_ready;
   logic [DATA_W-1:0] if_rdata;
   logic              if_resp_err;

   logic              ls_req_valid;
   logic              ls_req_ready;
   logic [ADDR_W-1:0] ls_addr;
   logic              ls_wen;
   logic [DATA_W-1:0] ls_wdata;
   logic [DATA_W-1:0] ls_wmask;
   logic              ls_resp_valid;
   logic              ls_resp_ready;
   logic [DATA_W-1:0] ls_rdata;
   logic              ls_resp_err;

   logic              ram_en;
   logic [ADDR_W-1:0] ram_idx;
   logic              ram_wen;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_wmask;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output if_req_valid, if_addr, if_resp_ready,
      output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask, ls_resp_ready,
      output ram_rdata,
      input  if_req_ready, if_resp_valid, if_rdata, if_resp_err,
      input  ls_req_ready, ls_resp_valid, ls_rdata, ls_resp_err,
      input  ram_en, ram_idx, ram_wen, ram_wdata, ram_wmask
   );

   modport slave (
      input  if_req_valid, if_addr, if_resp_ready,
      input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask, ls_resp_ready,
      input  ram_rdata,
      output if_req_ready, if_resp_valid, if_rdata, if_resp_err,
      output ls_req_ready, ls_resp_valid, ls_rdata, ls_resp_err,
      output ram_en, ram_idx, ram_wen, ram_wdata, ram_wmask
   );
endinterface

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Single-port data memory arbiter between instruction fetch and load/store.
// One transaction in flight; LS has priority, bounded so a waiting IF is never starved.
module ysyx_22040759_mem_arbiter #(
   parameter int unsigned       ADDR_W     = 64,
   parameter int unsigned       DATA_W     = 64,
   parameter logic [ADDR_W-1:0] RAM_BASE   = ADDR_W'(64'h8000_0000),
   parameter logic [ADDR_W-1:0] RAM_WORDS  = ADDR_W'(64'h0800_0000),
   parameter int unsigned       STARVE_MAX = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   ysyx_22040759_mem_arbiter_if.slave bus
);
   localparam int unsigned          STARVE_W   = $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e              state_q, state_d;
   logic                owner_ls_q, owner_ls_d;
   logic                wen_q, wen_d;
   logic                err_q, err_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   logic                ram_en_q, ram_en_d;
   logic [ADDR_W-1:0]   ram_idx_q, ram_idx_d;
   logic                ram_wen_q, ram_wen_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0]   ram_wmask_q, ram_wmask_d;

   logic                if_resp_valid_q, if_resp_valid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic                if_resp_err_q, if_resp_err_d;
   logic                ls_resp_valid_q, ls_resp_valid_d;
   logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
   logic                ls_resp_err_q, ls_resp_err_d;

   logic                idle_c, grant_ls_c, grant_if_c, req_oor_c;
   logic [ADDR_W-1:0]   req_addr_c, req_off_c, req_idx_c;

   // Arbitration and range check of whichever request wins this cycle
   always_comb begin
      idle_c     = (state_q == S_IDLE) && rst_n;
      grant_ls_c = idle_c && bus.ls_req_valid &&
                   ((starve_q < STARVE_LIM) || !bus.if_req_valid);
      grant_if_c = idle_c && bus.if_req_valid && !grant_ls_c;
      req_addr_c = grant_ls_c ? bus.ls_addr : bus.if_addr;
      req_off_c  = req_addr_c - RAM_BASE;
      req_idx_c  = {3'b000, req_off_c[ADDR_W-1:3]};
      req_oor_c  = (req_addr_c < RAM_BASE) || (req_idx_c >= RAM_WORDS);
   end

   assign bus.if_req_ready = idle_c && !grant_ls_c;
   assign bus.ls_req_ready = idle_c && !grant_if_c;

   // Next state; RAM strobes are loaded at accept so they appear exactly in ISSUE
   always_comb begin
      state_d         = state_q;
      owner_ls_d      = owner_ls_q;
      wen_d           = wen_q;
      err_d           = err_q;
      starve_d        = starve_q;
      ram_en_d        = 1'b0;
      ram_idx_d       = '0;
      ram_wen_d       = 1'b0;
      ram_wdata_d     = '0;
      ram_wmask_d     = '0;
      if_resp_valid_d = if_resp_valid_q;
      if_rdata_d      = if_rdata_q;
      if_resp_err_d   = if_resp_err_q;
      ls_resp_valid_d = ls_resp_valid_q;
      ls_rdata_d      = ls_rdata_q;
      ls_resp_err_d   = ls_resp_err_q;

      case (state_q)
         S_IDLE: begin
            if (grant_ls_c || grant_if_c) begin
               state_d     = S_ISSUE;
               owner_ls_d  = grant_ls_c;
               wen_d       = grant_ls_c && bus.ls_wen;
               err_d       = req_oor_c;
               ram_en_d    = !req_oor_c;
               ram_idx_d   = req_oor_c ? '0 : req_idx_c;
               ram_wen_d   = wen_d && !req_oor_c;
               ram_wdata_d = ram_wen_d ? bus.ls_wdata : '0;
               ram_wmask_d = ram_wen_d ? bus.ls_wmask : '0;
               if (grant_ls_c && bus.if_req_valid)
                  starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + STARVE_W'(1);
               else
                  starve_d = '0;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            state_d = S_RESP;
            if (owner_ls_q) begin
               ls_resp_valid_d = 1'b1;
               ls_rdata_d      = (err_q || wen_q) ? '0 : bus.ram_rdata;
               ls_resp_err_d   = err_q;
            end else begin
               if_resp_valid_d = 1'b1;
               if_rdata_d      = err_q ? '0 : bus.ram_rdata;
               if_resp_err_d   = err_q;
            end
         end
         S_RESP: begin
            if (owner_ls_q ? bus.ls_resp_ready : bus.if_resp_ready) begin
               state_d         = S_IDLE;
               ls_resp_valid_d = 1'b0;
               if_resp_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         owner_ls_q      <= 1'b0;
         wen_q           <= 1'b0;
         err_q           <= 1'b0;
         starve_q        <= '0;
         ram_en_q        <= 1'b0;
         ram_idx_q       <= '0;
         ram_wen_q       <= 1'b0;
         ram_wdata_q     <= '0;
         ram_wmask_q     <= '0;
         if_resp_valid_q <= 1'b0;
         if_rdata_q      <= '0;
         if_resp_err_q   <= 1'b0;
         ls_resp_valid_q <= 1'b0;
         ls_rdata_q      <= '0;
         ls_resp_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         owner_ls_q      <= owner_ls_d;
         wen_q           <= wen_d;
         err_q           <= err_d;
         starve_q        <= starve_d;
         ram_en_q        <= ram_en_d;
         ram_idx_q       <= ram_idx_d;
         ram_wen_q       <= ram_wen_d;
         ram_wdata_q     <= ram_wdata_d;
         ram_wmask_q     <= ram_wmask_d;
         if_resp_valid_q <= if_resp_valid_d;
         if_rdata_q      <= if_rdata_d;
         if_resp_err_q   <= if_resp_err_d;
         ls_resp_valid_q <= ls_resp_valid_d;
         ls_rdata_q      <= ls_rdata_d;
         ls_resp_err_q   <= ls_resp_err_d;
      end
   end

   assign bus.ram_en        = ram_en_q;
   assign bus.ram_idx       = ram_idx_q;
   assign bus.ram_wen       = ram_wen_q;
   assign bus.ram_wdata     = ram_wdata_q;
   assign bus.ram_wmask     = ram_wmask_q;
   assign bus.if_resp_valid = if_resp_valid_q;
   assign bus.if_rdata      = if_rdata_q;
   assign bus.if_resp_err   = if_resp_err_q;
   assign bus.ls_resp_valid = ls_resp_valid_q;
   assign bus.ls_rdata      = ls_rdata_q;
   assign bus.ls_resp_err   = ls_resp_err_q;
endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed bench for the IF/LS memory arbiter: latency, stores, range errors,
// starvation bound, response back-pressure and mid-transaction reset.
module tb_ysyx_22040759_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_done = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [63:0] mem [16];

   ysyx_22040759_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   ysyx_22040759_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // RAM helper model: synchronous read, bit-masked write, 16 words aliased on idx[3:0]
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 16; i++) mem[i] <= 64'h1000 + 64'(i);
         mem[2] <= 64'hDEAD;
         bus.ram_rdata <= '0;
      end else if (bus.ram_en) begin
         bus.ram_rdata <= mem[bus.ram_idx[3:0]];
         if (bus.ram_wen)
            mem[bus.ram_idx[3:0]] <= (mem[bus.ram_idx[3:0]] & ~bus.ram_wmask) |
                                     (bus.ram_wdata & bus.ram_wmask);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated transaction from IDLE, checking handshake, RAM strobe and response timing
   task automatic transact(input string tag, input bit is_ls, input logic [63:0] addr,
                           input bit wen, input logic [63:0] wdata, input logic [63:0] wmask,
                           input bit exp_en, input logic [63:0] exp_idx,
                           input logic [63:0] exp_wmask, input logic [63:0] exp_rdata,
                           input bit exp_err, input int stall);
      if (is_ls) begin
         bus.ls_req_valid = 1'b1; bus.ls_addr = addr; bus.ls_wen = wen;
         bus.ls_wdata = wdata; bus.ls_wmask = wmask;
      end else begin
         bus.if_req_valid = 1'b1; bus.if_addr = addr;
      end
      #1;
      check({tag, "_req_ready"}, is_ls ? bus.ls_req_ready : bus.if_req_ready, 1);
      step();
      bus.ls_req_valid = 1'b0; bus.if_req_valid = 1'b0;
      bus.ls_addr = '0; bus.if_addr = '0; bus.ls_wen = 1'b0;
      bus.ls_wdata = '1; bus.ls_wmask = '1;
      check({tag, "_ram_en"}, bus.ram_en, exp_en);
      if (exp_en) begin
         check({tag, "_ram_idx"}, bus.ram_idx, exp_idx);
         check({tag, "_ram_wen"}, bus.ram_wen, is_ls && wen);
         check({tag, "_ram_wmask"}, bus.ram_wmask, exp_wmask);
      end
      step();
      check({tag, "_wait_ram_en"}, bus.ram_en, 0);
      check({tag, "_early_resp"}, is_ls ? bus.ls_resp_valid : bus.if_resp_valid, 0);
      step();
      for (int s = 0; s <= stall; s++) begin
         check({tag, "_resp_valid"}, is_ls ? bus.ls_resp_valid : bus.if_resp_valid, 1);
         check({tag, "_rdata"}, is_ls ? bus.ls_rdata : bus.if_rdata, exp_rdata);
         check({tag, "_err"}, is_ls ? bus.ls_resp_err : bus.if_resp_err, exp_err);
         if (s < stall) begin
            check({tag, "_stall_ready"}, {62'd0, bus.if_req_ready, bus.ls_req_ready}, 0);
            step();
         end
      end
      if (is_ls) bus.ls_resp_ready = 1'b1; else bus.if_resp_ready = 1'b1;
      step();
      bus.ls_resp_ready = 1'b0; bus.if_resp_ready = 1'b0;
      check({tag, "_resp_done"}, {62'd0, bus.if_resp_valid, bus.ls_resp_valid}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_g[6] = '{1, 1, 1, 1, 0, 1};
      int ng;
      int budget;
      logic g;

      bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.if_resp_ready = 1'b0;
      bus.ls_req_valid = 1'b0; bus.ls_addr = '0; bus.ls_wen = 1'b0;
      bus.ls_wdata = '0; bus.ls_wmask = '0; bus.ls_resp_ready = 1'b0;

      repeat (3) @(posedge clk);
      init_done = 1'b1;
      #1;
      check("rst_ready", {62'd0, bus.if_req_ready, bus.ls_req_ready}, 0);
      check("rst_ram_en", bus.ram_en, 0);
      check("rst_resp", {62'd0, bus.if_resp_valid, bus.ls_resp_valid}, 0);
      check("rst_rdata", bus.if_rdata | bus.ls_rdata, 0);
      step();
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", {62'd0, bus.if_req_ready, bus.ls_req_ready}, 2'b11);
      step();

      transact("if_rd",      0, 64'h8000_0010, 0, 0, 0, 1, 64'd2, 0, 64'hDEAD, 0, 0);
      transact("ls_st",      1, 64'h8000_0008, 1, 64'hAB00, 64'hFF00, 1, 64'd1, 64'hFF00, 0, 0, 0);
      transact("ls_ld_stall",1, 64'h8000_000C, 0, 0, 0, 1, 64'd1, 0, 64'hAB01, 0, 5);
      transact("ls_below",   1, 64'h7FFF_FFF8, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      transact("if_above",   0, 64'hC000_0000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      transact("ls_top",     1, 64'hBFFF_FFF8, 0, 0, 0, 1, 64'h07FF_FFFF, 0, 64'h100F, 0, 0);
      transact("ls_st_oor",  1, 64'hC000_0008, 1, 64'h55, 64'hFF, 0, 0, 0, 0, 1, 0);

      // Both requesters busy: LS wins STARVE_MAX times, then IF is forced once
      bus.ls_req_valid = 1'b1; bus.ls_addr = 64'h8000_0000; bus.ls_wen = 1'b0;
      bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_0008;
      bus.ls_resp_ready = 1'b1; bus.if_resp_ready = 1'b1;
      ng = 0;
      budget = 0;
      while (ng < 6 && budget < 80) begin
         #1;
         if ((bus.ls_req_valid && bus.ls_req_ready) || (bus.if_req_valid && bus.if_req_ready)) begin
            g = bus.ls_req_ready;
            check($sformatf("grant%0d", ng), {63'd0, g}, 64'(exp_g[ng]));
            ng++;
         end
         step();
         budget++;
      end
      if (ng < 6) check("grant_timeout", 64'(ng), 64'd6);
      bus.ls_req_valid = 1'b0; bus.if_req_valid = 1'b0;
      repeat (6) step();
      bus.ls_resp_ready = 1'b0; bus.if_resp_ready = 1'b0;
      check("fair_drained", {62'd0, bus.if_req_ready, bus.ls_req_ready}, 2'b11);

      // Reset while the read is waiting on RAM data drops the transaction
      bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_0010;
      step();
      bus.if_req_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_ram_en", bus.ram_en, 0);
      check("midrst_ready", {62'd0, bus.if_req_ready, bus.ls_req_ready}, 0);
      check("midrst_resp", {62'd0, bus.if_resp_valid, bus.ls_resp_valid}, 0);
      check("midrst_rdata", bus.if_rdata, 0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         check("postrst_no_resp", {62'd0, bus.if_resp_valid, bus.ls_resp_valid}, 0);
      end
      check("postrst_ready", {62'd0, bus.if_req_ready, bus.ls_req_ready}, 2'b11);
      transact("if_after_rst", 0, 64'h8000_0018, 0, 0, 0, 1, 64'd3, 0, 64'h1003, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
